picobus128_master: RTL and testbench
====================================

Name: picobus128_master

Overview:
- Initiator side of the 128-bit PicoBus: converts a valid/ready request stream into single-cycle PicoBus read/write strobes.
- Captures read data returned by slaves a fixed number of cycles later and presents it as a valid/ready response.
- Sits between firmware control logic (e.g. the scan sequencer) and one or more PicoBus register slaves whose outputs are OR-combined onto m_rdata.
- Keeps read/write transaction counters for debug.

Parameters:
- ADDR_W, 32, PicoBus address width.
- DATA_W, 128, PicoBus data width.
- READ_LATENCY, 1, cycles from the m_rd strobe cycle to the cycle m_rdata is valid (1..7).

Ports:
- PicoClk  in  1  single clock; all logic on rising edge.
- PicoRst_n  in  1  reset, asynchronous assert, active-low; clears all state.
- req_valid  in  1  request present.
- req_ready  out  1  master accepts request this cycle.
- req_wr  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  byte address; must be 16-byte aligned.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  DATA_W  read data (0 for writes/errors).
- rsp_err  out  1  misaligned address; no bus cycle issued.
- rsp_is_wr  out  1  response belongs to a write.
- m_addr  out  ADDR_W  PicoBus address (to slave PicoAddr).
- m_wdata  out  DATA_W  PicoBus write data (to slave PicoDataIn).
- m_rd  out  1  PicoBus read strobe.
- m_wr  out  1  PicoBus write strobe.
- m_rdata  in  DATA_W  OR of all slave PicoDataOut.
- rd_count  out  32  completed bus reads, wraps at 2^32.
- wr_count  out  32  completed bus writes, wraps at 2^32.

Behaviour:
- Reset values: every output is 0. FSM is in IDLE; req_ready becomes 1 on the first cycle after deassertion.
- All outputs are registered except req_ready, which equals (state==IDLE).
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Handshake when req_valid && req_ready (cycle T); latch addr, wdata and wr.
  - If req_addr[3:0]!=0: go to RESP with rsp_err=1, rsp_rdata=0, rsp_is_wr=req_wr. No strobe is issued and counters are unchanged.
  - Otherwise go to ISSUE.
- ISSUE (cycle T+1):
  - m_addr/m_wdata are driven with the latched values.
  - Exactly one of m_wr or m_rd is high, for exactly this one cycle.
  - Write: wr_count++, next state RESP, rsp_rdata=0.
  - Read: load latency counter with READ_LATENCY, next state WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - On the cycle it reaches 1 (cycle T+1+READ_LATENCY), register m_rdata into rsp_rdata, rd_count++, go to RESP.
- RESP:
  - rsp_valid=1; rsp_* fields are stable until rsp_valid && rsp_ready.
  - After that handshake, return to IDLE. req_ready becomes 1 on the next cycle, so there is one outstanding transaction maximum.
- m_addr and m_wdata return to 0 in every cycle where neither strobe is high. Idle bus output must be all-zero, because the bus is shared and OR-combined.
- Latency:
  - Write response valid at T+2.
  - Read response valid at T+2+READ_LATENCY (T+3 at default).
  - Minimum throughput: one write per 3 cycles, one read per 4 cycles at default, when rsp_ready is held high.
- m_rdata is sampled only in the WAIT capture cycle; it is ignored at all other times.
- req_* changes while req_ready=0 are ignored.
- Reset asserted mid-transaction:
  - State, strobes, response and counters clear immediately (asynchronously).
  - The in-flight transaction is dropped and no response is produced.
- Counters wrap 0xFFFFFFFF->0 without a flag.

Test Plan:
- Write, address 0x10, data 0x0123...EF, rsp_ready=1 -> m_wr high for exactly 1 cycle at T+1 with m_addr=0x10; rsp_valid at T+2 with rsp_is_wr=1, rsp_err=0; wr_count=1.
- Read 0x30 against a register slave holding 5 (READ_LATENCY=1) -> m_rd pulse at T+1; rsp_valid at T+3 with rsp_rdata=5; rd_count=1.
- Misaligned read 0x08 -> no m_rd/m_wr pulse; rsp_valid at T+1 with rsp_err=1 and rsp_rdata=0; counters unchanged.
- Read with rsp_ready held low for 10 cycles:
  - rsp_valid and rsp_rdata hold; req_ready=0 throughout, and a pending req_valid is not accepted.
  - After rsp_ready pulses, req_ready returns the following cycle.
- Back-to-back: 4 writes then 4 reads, with req_valid held high -> strobes never overlap; m_addr/m_wdata are 0 between strobes; final counts wr_count=4, rd_count=4.
- PicoRst_n pulsed low during WAIT -> all outputs 0 immediately; no rsp_valid afterwards; the next read completes normally with rd_count=1.

Source files
------------

// File: rtl/picobus128_master.sv
// PicoBus 128-bit initiator: turns a valid/ready request stream into single-cycle bus strobes
// and returns read data, write acks and alignment errors as a valid/ready response.
`timescale 1ns/1ps
module picobus128_master #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 128,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              PicoClk,
  input  logic              PicoRst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_is_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_rd,
  output logic              m_wr,
  input  logic [DATA_W-1:0] m_rdata,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StResp  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              rdy_q, rdy_d;
  logic              wr_q, wr_d;
  logic [2:0]        lat_q, lat_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic              m_rd_q, m_rd_d;
  logic              m_wr_q, m_wr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_is_wr_q, rsp_is_wr_d;
  logic [31:0]       rd_count_q, rd_count_d;
  logic [31:0]       wr_count_q, wr_count_d;

  always_comb begin
    state_d     = state_q;
    rdy_d       = 1'b1;
    wr_d        = wr_q;
    lat_d       = lat_q;
    // Bus outputs default to zero so an idle master never pollutes the OR-combined bus.
    m_addr_d    = '0;
    m_wdata_d   = '0;
    m_rd_d      = 1'b0;
    m_wr_d      = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_is_wr_d = rsp_is_wr_q;
    rd_count_d  = rd_count_q;
    wr_count_d  = wr_count_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid && rdy_q) begin
          if (req_addr[3:0] != 4'd0) begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            rsp_is_wr_d = req_wr;
          end else begin
            state_d   = StIssue;
            wr_d      = req_wr;
            m_addr_d  = req_addr;
            m_wdata_d = req_wdata;
            m_wr_d    = req_wr;
            m_rd_d    = ~req_wr;
          end
        end
      end
      StIssue: begin
        if (wr_q) begin
          wr_count_d  = wr_count_q + 32'd1;
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
          rsp_is_wr_d = 1'b1;
        end else begin
          lat_d   = 3'(READ_LATENCY);
          state_d = StWait;
        end
      end
      StWait: begin
        if (lat_q == 3'd1) begin
          rsp_rdata_d = m_rdata;
          rd_count_d  = rd_count_q + 32'd1;
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_is_wr_d = 1'b0;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          rsp_is_wr_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge PicoClk or negedge PicoRst_n) begin
    if (!PicoRst_n) begin
      state_q     <= StIdle;
      rdy_q       <= 1'b0;
      wr_q        <= 1'b0;
      lat_q       <= 3'd0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      m_rd_q      <= 1'b0;
      m_wr_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_is_wr_q <= 1'b0;
      rd_count_q  <= '0;
      wr_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= rdy_d;
      wr_q        <= wr_d;
      lat_q       <= lat_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      m_rd_q      <= m_rd_d;
      m_wr_q      <= m_wr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_is_wr_q <= rsp_is_wr_d;
      rd_count_q  <= rd_count_d;
      wr_count_q  <= wr_count_d;
    end
  end

  // rdy_q keeps req_ready low while reset is held and until the first clock after release.
  assign req_ready = (state_q == StIdle) && rdy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_is_wr = rsp_is_wr_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign m_rd      = m_rd_q;
  assign m_wr      = m_wr_q;
  assign rd_count  = rd_count_q;
  assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_picobus128_master.sv
// Bench for picobus128_master: transaction-level latency model compared every cycle, a bus
// register slave, and directed scenarios with hand-computed literal expectations.
`timescale 1ns/1ps
module tb_picobus128_master;
  localparam int unsigned RL = 1;
  localparam logic [127:0] NOISE = 128'hDEAD_BEEF_0BAD_F00D_CAFE_BABE_1234_5678;

  logic         PicoClk = 1'b0;
  logic         PicoRst_n = 1'b0;
  logic         req_valid = 1'b0, req_wr = 1'b0, rsp_ready = 1'b1;
  logic [31:0]  req_addr = '0;
  logic [127:0] req_wdata = '0;
  logic         req_ready, rsp_valid, rsp_err, rsp_is_wr, m_rd, m_wr;
  logic [127:0] rsp_rdata, m_wdata, m_rdata;
  logic [31:0]  m_addr, rd_count, wr_count;

  int checks = 0;
  int errors = 0;

  always #5 PicoClk = ~PicoClk;

  picobus128_master #(.ADDR_W(32), .DATA_W(128), .READ_LATENCY(RL)) dut (
    .PicoClk(PicoClk), .PicoRst_n(PicoRst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_is_wr(rsp_is_wr),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rd(m_rd), .m_wr(m_wr), .m_rdata(m_rdata),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  function automatic logic [127:0] slave_val(input logic [31:0] a);
    if (a == 32'h30) return 128'd5;
    return {a, ~a, a ^ 32'h5A5A_5A5A, 32'hC0DE_0000 | a};
  endfunction

  // Register slave: data appears RL cycles after the read strobe, noise at all other times.
  logic        rd_sr [RL];
  logic [31:0] a_sr  [RL];
  always @(posedge PicoClk or negedge PicoRst_n) begin
    if (!PicoRst_n) begin
      for (int i = 0; i < RL; i++) begin rd_sr[i] <= 1'b0; a_sr[i] <= '0; end
    end else begin
      rd_sr[0] <= m_rd;
      a_sr[0]  <= m_addr;
      for (int i = 1; i < RL; i++) begin rd_sr[i] <= rd_sr[i-1]; a_sr[i] <= a_sr[i-1]; end
    end
  end
  assign m_rdata = rd_sr[RL-1] ? slave_val(a_sr[RL-1]) : NOISE;

  // Transaction model: k counts cycles since the accepting edge (k=1 is the strobe cycle).
  logic         mb_busy = 0, mb_rsp = 0, mb_err = 0, mb_wr = 0, mb_rdy = 0;
  int           mb_k = 0;
  logic [31:0]  mb_addr = '0, mb_rdc = '0, mb_wrc = '0;
  logic [127:0] mb_wdata = '0;

  function automatic int resp_k(input logic err, input logic wr);
    if (err) return 1;
    if (wr) return 2;
    return 2 + int'(RL);
  endfunction

  always @(posedge PicoClk or negedge PicoRst_n) begin
    if (!PicoRst_n) begin
      mb_busy <= 0; mb_rsp <= 0; mb_err <= 0; mb_wr <= 0; mb_rdy <= 0; mb_k <= 0;
      mb_addr <= '0; mb_wdata <= '0; mb_rdc <= '0; mb_wrc <= '0;
    end else begin
      mb_rdy <= 1'b1;
      if (!mb_busy) begin
        if (req_valid && mb_rdy) begin
          mb_busy  <= 1'b1;
          mb_k     <= 1;
          mb_wr    <= req_wr;
          mb_addr  <= req_addr;
          mb_wdata <= req_wdata;
          mb_err   <= (req_addr[3:0] != 4'd0);
          mb_rsp   <= (req_addr[3:0] != 4'd0);
        end
      end else if (mb_rsp) begin
        if (rsp_ready) begin mb_busy <= 1'b0; mb_rsp <= 1'b0; end
      end else begin
        mb_k <= mb_k + 1;
        if (mb_k + 1 == resp_k(mb_err, mb_wr)) begin
          mb_rsp <= 1'b1;
          if (mb_wr) mb_wrc <= mb_wrc + 32'd1;
          else mb_rdc <= mb_rdc + 32'd1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge PicoClk) begin
    logic strobe;
    strobe = mb_busy && !mb_err && (mb_k == 1);
    chk("req_ready", 128'(req_ready), 128'(mb_rdy && !mb_busy));
    chk("m_wr", 128'(m_wr), 128'(strobe && mb_wr));
    chk("m_rd", 128'(m_rd), 128'(strobe && !mb_wr));
    chk("m_addr", 128'(m_addr), strobe ? 128'(mb_addr) : 128'd0);
    chk("m_wdata", m_wdata, strobe ? mb_wdata : 128'd0);
    chk("rsp_valid", 128'(rsp_valid), 128'(mb_rsp));
    chk("rd_count", 128'(rd_count), 128'(mb_rdc));
    chk("wr_count", 128'(wr_count), 128'(mb_wrc));
    if (mb_rsp) begin
      chk("rsp_err", 128'(rsp_err), 128'(mb_err));
      chk("rsp_is_wr", 128'(rsp_is_wr), 128'(mb_wr));
      chk("rsp_rdata", rsp_rdata, (mb_err || mb_wr) ? 128'd0 : slave_val(mb_addr));
    end
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge (cycle T+1).
  task automatic send(input logic wr, input logic [31:0] a, input logic [127:0] d);
    int n = 0;
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
    while (!req_ready && n < 100) begin @(posedge PicoClk); #1; n++; end
    if (n >= 100) chk("send_timeout", 128'd1, 128'd0);
    @(posedge PicoClk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (mb_busy && n < 200) begin @(posedge PicoClk); #1; n++; end
    if (n >= 200) chk("idle_timeout", 128'd1, 128'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_req_ready"}, 128'(req_ready), 128'd0);
    chk({tag, "_rsp_valid"}, 128'(rsp_valid), 128'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 128'd0);
    chk({tag, "_strobes"}, 128'({m_rd, m_wr, rsp_err, rsp_is_wr}), 128'd0);
    chk({tag, "_m_addr"}, 128'(m_addr), 128'd0);
    chk({tag, "_counts"}, 128'({rd_count, wr_count}), 128'd0);
  endtask

  localparam logic [127:0] WDATA = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  initial begin
    #1 check_zero("reset");
    #21 PicoRst_n = 1'b1;
    @(posedge PicoClk); #1;
    chk("ready_after_reset", 128'(req_ready), 128'd1);

    // Aligned write: strobe at T+1, response at T+2.
    send(1'b1, 32'h10, WDATA);
    chk("wr_strobe", 128'({m_wr, m_rd}), 128'b10);
    chk("wr_addr", 128'(m_addr), 128'h10);
    chk("wr_data", m_wdata, WDATA);
    @(posedge PicoClk); #1;
    chk("wr_rsp", 128'({rsp_valid, rsp_is_wr, rsp_err, m_wr}), 128'b1100);
    chk("wr_count1", 128'(wr_count), 128'd1);
    wait_idle();

    // Read of register holding 5: response at T+3.
    send(1'b0, 32'h30, '0);
    chk("rd_strobe", 128'({m_wr, m_rd}), 128'b01);
    @(posedge PicoClk); #1;
    chk("rd_not_yet", 128'(rsp_valid), 128'd0);
    @(posedge PicoClk); #1;
    chk("rd_rsp_valid", 128'(rsp_valid), 128'd1);
    chk("rd_rdata5", rsp_rdata, 128'd5);
    chk("rd_count1", 128'(rd_count), 128'd1);
    wait_idle();

    // Misaligned read: error response at T+1, no strobe.
    send(1'b0, 32'h08, '0);
    chk("mis_rsp", 128'({rsp_valid, rsp_err, m_rd, m_wr}), 128'b1100);
    chk("mis_rdata", rsp_rdata, 128'd0);
    chk("mis_counts", 128'({rd_count, wr_count}), {64'd0, 32'd1, 32'd1});
    wait_idle();

    // Backpressure: response held for 10 cycles with a pending write that must wait.
    rsp_ready = 1'b0;
    send(1'b0, 32'h50, '0);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h60; req_wdata = 128'hABCD;
    repeat (10) begin @(posedge PicoClk); #1; end
    chk("bp_hold", 128'({rsp_valid, req_ready}), 128'b10);
    chk("bp_rdata", rsp_rdata, slave_val(32'h50));
    rsp_ready = 1'b1;
    @(posedge PicoClk); #1;
    chk("bp_ready_back", 128'(req_ready), 128'd1);
    @(posedge PicoClk); #1;
    req_valid = 1'b0;
    wait_idle();
    chk("bp_counts", 128'({rd_count, wr_count}), {64'd0, 32'd2, 32'd2});

    // Back-to-back from a fresh reset: 4 writes then 4 reads with req_valid held.
    PicoRst_n = 1'b0; #2 PicoRst_n = 1'b1;
    @(posedge PicoClk); #1;
    for (int i = 0; i < 4; i++) send(1'b1, 32'h100 + 32'(16 * i), WDATA ^ 128'(i));
    for (int i = 0; i < 4; i++) send(1'b0, 32'h200 + 32'(16 * i), '0);
    wait_idle();
    chk("b2b_counts", 128'({rd_count, wr_count}), {64'd0, 32'd4, 32'd4});

    // Reset during WAIT drops the read; the next read completes normally.
    send(1'b0, 32'h40, '0);
    @(posedge PicoClk); #1;
    PicoRst_n = 1'b0;
    #1 check_zero("midreset");
    #2 PicoRst_n = 1'b1;
    repeat (5) begin @(posedge PicoClk); #1; end
    chk("no_rsp_after_reset", 128'(rsp_valid), 128'd0);
    send(1'b0, 32'h30, '0);
    wait_idle();
    chk("post_reset_counts", 128'({rd_count, wr_count}), {64'd0, 32'd1, 32'd0});

    repeat (3) @(posedge PicoClk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
